// File: rtl/iob_ram_bist.sv
// Self-test initiator for a single-port RAM with a 1-cycle registered read.
// Fills every word with seed+addr, reads it all back and reports the mismatches.
module iob_ram_bist #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        LAST,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ERR_MAX  = {(ADDR_W+1){1'b1}};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt, cnt_inc, cnt_prev;
    logic [DATA_W-1:0] seed_q, seed_q_nxt, expected;
    logic              compare_en, mismatch;

    logic              busy_nxt, done_nxt, pass_nxt;
    logic [ADDR_W:0]   err_cnt_nxt;
    logic [ADDR_W-1:0] err_addr_nxt;
    logic [DATA_W-1:0] err_data_nxt;
    logic              mem_w_en_nxt, mem_r_en_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_w_data_nxt;

    // Every output is registered, so the comb block computes the values for the
    // next cycle; cnt is the address being presented during the current cycle.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        seed_q_nxt     = seed_q;
        busy_nxt       = busy;
        done_nxt       = done;
        pass_nxt       = pass;
        err_cnt_nxt    = err_cnt;
        err_addr_nxt   = err_addr;
        err_data_nxt   = err_data;
        mem_w_en_nxt   = 1'b0;
        mem_r_en_nxt   = 1'b0;
        mem_addr_nxt   = '0;
        mem_w_data_nxt = '0;

        cnt_inc  = cnt + CNT_ONE;
        cnt_prev = cnt - CNT_ONE;
        expected = seed_q + DATA_W'(cnt_prev);
        mismatch = (mem_r_data != expected);

        // Read data always belongs to the address presented one cycle earlier.
        compare_en = ((state == READ) && (cnt != '0)) || (state == LAST);

        if (compare_en && mismatch) begin
            if (err_cnt != ERR_MAX) begin
                err_cnt_nxt = err_cnt + CNT_ONE;
            end
            if (err_cnt == '0) begin
                err_addr_nxt = cnt_prev[ADDR_W-1:0];
                err_data_nxt = mem_r_data;
            end
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt      = WRITE;
                    cnt_nxt        = '0;
                    seed_q_nxt     = seed;
                    busy_nxt       = 1'b1;
                    done_nxt       = 1'b0;
                    pass_nxt       = 1'b0;
                    err_cnt_nxt    = '0;
                    err_addr_nxt   = '0;
                    err_data_nxt   = '0;
                    mem_w_en_nxt   = 1'b1;
                    mem_w_data_nxt = seed;
                end
            end
            WRITE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt    = READ;
                    cnt_nxt      = '0;
                    mem_r_en_nxt = 1'b1;
                end else begin
                    cnt_nxt        = cnt_inc;
                    mem_w_en_nxt   = 1'b1;
                    mem_addr_nxt   = cnt_inc[ADDR_W-1:0];
                    mem_w_data_nxt = seed_q + DATA_W'(cnt_inc);
                end
            end
            READ: begin
                cnt_nxt = cnt_inc;
                if (cnt == CNT_LAST) begin
                    state_nxt = LAST;
                end else begin
                    mem_r_en_nxt = 1'b1;
                    mem_addr_nxt = cnt_inc[ADDR_W-1:0];
                end
            end
            LAST: begin
                state_nxt = DONE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                pass_nxt  = (err_cnt_nxt == '0);
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // A low rst_n wins over everything, including a coincident start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            seed_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            err_addr   <= '0;
            err_data   <= '0;
            mem_w_en   <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_addr   <= '0;
            mem_w_data <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            seed_q     <= seed_q_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_cnt    <= err_cnt_nxt;
            err_addr   <= err_addr_nxt;
            err_data   <= err_data_nxt;
            mem_w_en   <= mem_w_en_nxt;
            mem_r_en   <= mem_r_en_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_w_data <= mem_w_data_nxt;
        end
    end

endmodule

// File: tb/tb_iob_ram_bist.sv
// Bench for iob_ram_bist: 1-cycle-read RAM with fault injection, a cycle-level
// expectation model and directed runs pinned by literal results.
module tb_iob_ram_bist;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int N      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [DATA_W-1:0] seed;
    logic              busy, done, pass;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;
    logic              mem_w_en, mem_r_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data = '0;

    always #5 clk = ~clk;

    iob_ram_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .err_addr(err_addr), .err_data(err_data),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
    );

    // RAM with per-address read faults: XOR mask or stuck-at-0.
    logic [DATA_W-1:0] ram      [N] = '{default: '0};
    logic [DATA_W-1:0] xor_mask [N];
    logic              stuck0   [N];

    always @(posedge clk) begin
        if (mem_w_en) ram[mem_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= stuck0[mem_addr] ? '0 : (ram[mem_addr] ^ xor_mask[mem_addr]);
    end

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mk counts cycles since the accepted start (0 = idle after reset,
    // 2N+2 = done); end-of-run results are worked out from the fault tables.
    int                mk = 0;
    bit                model_valid = 0;
    logic [DATA_W-1:0] m_seed, wr_v, rd_v;
    int                m_cnt, m_addr, m_data;
    bit                m_pass;

    always @(posedge clk) begin
        if (!rst_n) begin
            mk = 0;
            model_valid = 1;
        end else if (model_valid) begin
            if (start && (mk == 0 || mk == 2*N+2)) begin
                mk = 1;
                m_seed = seed;
                m_cnt = 0; m_addr = 0; m_data = 0;
                for (int a = 0; a < N; a++) begin
                    wr_v = seed + DATA_W'(a);
                    rd_v = stuck0[a] ? '0 : (wr_v ^ xor_mask[a]);
                    if (rd_v != wr_v) begin
                        if (m_cnt == 0) begin
                            m_addr = a;
                            m_data = int'(rd_v);
                        end
                        m_cnt++;
                    end
                end
                m_pass = (m_cnt == 0);
            end else if (mk != 0 && mk < 2*N+2) begin
                mk++;
            end
        end
    end

    logic [DATA_W-1:0] e_wdata;
    bit                e_busy, e_done, e_w, e_r;
    int                e_addr;

    always @(negedge clk) begin
        if (model_valid) begin
            e_busy  = (mk >= 1 && mk <= 2*N+1);
            e_done  = (mk == 2*N+2);
            e_w     = (mk >= 1 && mk <= N);
            e_r     = (mk >= N+1 && mk <= 2*N);
            e_addr  = e_w ? mk-1 : (e_r ? mk-N-1 : 0);
            e_wdata = m_seed + DATA_W'(mk-1);
            checkOutput("busy", busy, e_busy);
            checkOutput("done", done, e_done);
            checkOutput("mem_w_en", mem_w_en, e_w);
            checkOutput("mem_r_en", mem_r_en, e_r);
            checkOutput("mem_addr", mem_addr, e_addr);
            if (e_w) checkOutput("mem_w_data", mem_w_data, e_wdata);
            if (mk <= N) checkOutput("err_cnt_run", err_cnt, 0);
            if (!e_done) checkOutput("pass_low", pass, 0);
            if (e_done) begin
                checkOutput("pass", pass, m_pass);
                checkOutput("err_cnt", err_cnt, m_cnt);
                checkOutput("err_addr", err_addr, m_addr);
                checkOutput("err_data", err_data, m_data);
            end
        end
    end

    // One run: start at cycle 0, optional second start or reset at a given cycle.
    task automatic applyStimulus(input logic [DATA_W-1:0] s, input int restart_cyc,
                                 input logic [DATA_W-1:0] restart_seed, input int reset_cyc,
                                 output int done_cyc, output int busy_cyc);
        int cyc;
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_clears_done", done, 0);
        cyc = 1;
        done_cyc = -1;
        busy_cyc = 0;
        while (cyc < 200) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) busy_cyc++;
            if (cyc == reset_cyc) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_w_en", mem_w_en, 0);
                checkOutput("rst_addr", mem_addr, 0);
                break;
            end
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) seed = restart_seed;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic clearFaults();
        for (int a = 0; a < N; a++) begin
            xor_mask[a] = '0;
            stuck0[a]   = 1'b0;
        end
    endtask

    int dc, bc;

    initial begin
        clearFaults();
        rst_n = 1'b0;
        start = 1'b0;
        seed  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] clean run");
        applyStimulus(8'd32, -1, 8'd0, -1, dc, bc);
        checkOutput("clean_done_cycle", dc, 34);
        checkOutput("clean_busy_cycles", bc, 33);
        checkOutput("clean_pass", pass, 1);
        checkOutput("clean_err_cnt", err_cnt, 0);
        checkOutput("clean_ram0", ram[0], 32);
        checkOutput("clean_ram7", ram[7], 39);
        checkOutput("clean_ram15", ram[15], 47);

        $display("[TB] single fault");
        xor_mask[5] = 8'h01;
        applyStimulus(8'd32, -1, 8'd0, -1, dc, bc);
        checkOutput("single_pass", pass, 0);
        checkOutput("single_err_cnt", err_cnt, 1);
        checkOutput("single_err_addr", err_addr, 5);
        checkOutput("single_err_data", err_data, 36);
        clearFaults();

        $display("[TB] multiple faults");
        stuck0[3] = 1'b1; stuck0[9] = 1'b1; stuck0[15] = 1'b1;
        applyStimulus(8'd32, -1, 8'd0, -1, dc, bc);
        checkOutput("multi_err_cnt", err_cnt, 3);
        checkOutput("multi_err_addr", err_addr, 3);
        checkOutput("multi_err_data", err_data, 0);
        checkOutput("multi_pass", pass, 0);
        clearFaults();

        $display("[TB] wrap-around");
        applyStimulus(8'd250, -1, 8'd0, -1, dc, bc);
        checkOutput("wrap_ram5", ram[5], 255);
        checkOutput("wrap_ram6", ram[6], 0);
        checkOutput("wrap_ram15", ram[15], 9);
        checkOutput("wrap_pass", pass, 1);

        $display("[TB] start while busy, restart from done");
        applyStimulus(8'd32, 10, 8'd99, -1, dc, bc);
        checkOutput("busy_start_done_cycle", dc, 34);
        checkOutput("busy_start_ram0", ram[0], 32);
        checkOutput("busy_start_ram15", ram[15], 47);
        applyStimulus(8'd99, -1, 8'd0, -1, dc, bc);
        checkOutput("restart_done_cycle", dc, 34);
        checkOutput("restart_ram0", ram[0], 99);
        checkOutput("restart_ram15", ram[15], 114);
        checkOutput("restart_pass", pass, 1);

        $display("[TB] reset mid-run");
        applyStimulus(8'd32, -1, 8'd0, 8, dc, bc);
        repeat (4) @(negedge clk);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_w_en", mem_w_en, 0);
        applyStimulus(8'd32, -1, 8'd0, -1, dc, bc);
        checkOutput("after_reset_done_cycle", dc, 34);
        checkOutput("after_reset_pass", pass, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
